// File: rtl/uart_rx_axis_fifo.sv
// UART receiver with glitch-rejecting start detection, run-time frame format,
// per-char error tagging and an RX FIFO presented as an AXI-Stream master.
module uart_rx_axis_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic [7:0]                    m_axis_tdata,
  output logic [1:0]                    m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_stop_bits,
  input  logic [2:0]                    cfg_parity,
  input  logic                          err_clr,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // state     | meaning
  // S_IDLE    | line idle, waiting for a falling edge
  // S_START   | qualifying the start bit at mid-bit
  // S_DATA    | shifting in data bits, LSB first
  // S_PARITY  | checking the parity bit
  // S_STOP    | sampling 1 or 2 stop bits, push at the last one
  // S_WAIT_HIGH | line still low after the frame (break), wait for idle
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t state, state_nx;

  logic             rx_meta, rx_s, rx_prev;
  logic [DIV_W-1:0] cnt, div_q;
  logic [1:0]       bits_q;
  logic             stop2_q;
  logic [2:0]       par_q;
  logic [3:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       shreg, data_now;
  logic             perr, ferr;
  logic             sample, wrap, par_en, par_exp, last_bit, push;
  logic [9:0]       push_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign sample   = (cnt == (div_q >> 1));
  assign wrap     = (cnt == div_q);
  assign par_en   = (par_q != 3'd0) && (par_q <= 3'd4);
  assign last_bit = (bit_idx == ({2'b00, bits_q} + 4'd5));

  // Bits arrive at the top of shreg, so a short char sits left-justified.
  always_comb begin
    case (bits_q)
      2'd0:    data_now = {3'b000, shreg[7:3]};
      2'd1:    data_now = {2'b00, shreg[7:2]};
      2'd2:    data_now = {1'b0, shreg[7:1]};
      default: data_now = shreg;
    endcase
  end

  always_comb begin
    case (par_q)
      3'd1:    par_exp = ^data_now;
      3'd2:    par_exp = ~^data_now;
      3'd3:    par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  assign push_word = {ferr | ~rx_s, perr, data_now};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // START/DATA/PARITY sample mid-bit but advance on wrap, keeping the next state bit-aligned.
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    case (state)
      S_IDLE:      if (rx_prev && !rx_s) state_nx = S_START;
      S_START: begin
        if (sample && rx_s) state_nx = S_IDLE;
        else if (wrap)      state_nx = S_DATA;
      end
      S_DATA:      if (wrap && last_bit) state_nx = par_en ? S_PARITY : S_STOP;
      S_PARITY:    if (wrap) state_nx = S_STOP;
      S_STOP: begin
        if (sample && (stop_idx == stop2_q)) begin
          push     = 1'b1;
          state_nx = rx_s ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: if (rx_s) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_q    <= '0;
      bits_q   <= '0;
      stop2_q  <= 1'b0;
      par_q    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (state_nx != state || wrap) cnt <= '0;
      else                           cnt <= cnt + 1'b1;

      if (state == S_IDLE && state_nx == S_START) begin
        div_q    <= cfg_div;
        bits_q   <= cfg_data_bits;
        stop2_q  <= cfg_stop_bits;
        par_q    <= cfg_parity;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        perr     <= 1'b0;
        ferr     <= 1'b0;
      end

      if (state == S_DATA && sample) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 4'd1;
      end
      if (state == S_PARITY && sample && (rx_s != par_exp)) perr <= 1'b1;
      if (state == S_STOP && sample && !rx_s)               ferr <= 1'b1;
      if (state == S_STOP && wrap)                          stop_idx <= 1'b1;
    end
  end

  assign rx_busy = (state != S_IDLE);

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, push_ok;

  assign m_axis_tvalid = (fifo_level != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  // level never exceeds FIFO_DEPTH, so its top bit alone means full
  assign push_ok       = push && (!fifo_level[AW] || pop);
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr][7:0] : 8'h00;
  assign m_axis_tuser  = m_axis_tvalid ? mem[rd_ptr][9:8] : 2'b00;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      err_parity  <= (push_ok & push_word[8]) | (err_parity & ~err_clr);
      err_frame   <= (push_ok & push_word[9]) | (err_frame & ~err_clr);
      err_overrun <= (push & ~push_ok)        | (err_overrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Directed bench for uart_rx_axis_fifo: serial frames are driven bit by bit and
// the expected {tuser, tdata} of every accepted char is queued for comparison.
module tb_uart_rx_axis_fifo;
  localparam int BIT = 16;

  logic        clk = 1'b0;
  logic        rst, uart_rx, tready, err_clr;
  logic [7:0]  tdata;
  logic [1:0]  tuser;
  logic        tvalid;
  logic [31:0] cfg_div;
  logic [1:0]  cfg_data_bits;
  logic        cfg_stop_bits;
  logic [2:0]  cfg_parity;
  logic        err_parity, err_frame, err_overrun, rx_busy;
  logic [4:0]  fifo_level;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [9:0]  sb_q[$];

  always #5 clk = ~clk;

  uart_rx_axis_fifo #(.FIFO_DEPTH(16), .DIV_W(32)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits), .cfg_stop_bits(cfg_stop_bits),
    .cfg_parity(cfg_parity), .err_clr(err_clr),
    .err_parity(err_parity), .err_frame(err_frame), .err_overrun(err_overrun),
    .fifo_level(fifo_level), .rx_busy(rx_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic xor_bits(input logic [7:0] d, input int nb);
    logic p = 1'b0;
    for (int i = 0; i < nb; i++) p ^= d[i];
    return p;
  endfunction

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  // par < 0 means no parity bit; otherwise par[0] is the bit put on the line.
  task automatic send_char(input logic [7:0] d, input int nb, input int par,
                           input int nstop, input logic stop_v,
                           input logic exp_push, input logic [1:0] exp_user);
    logic [7:0] mask;
    mask = 8'hFF >> (8 - nb);
    if (exp_push) sb_q.push_back({exp_user, d & mask});
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (par >= 0) send_bit(par[0]);
    for (int i = 0; i < nstop; i++) send_bit(stop_v);
  endtask

  task automatic expect_beat(input string tag);
    logic       got;
    logic [9:0] exp;
    got = 1'b0;
    tready = 1'b1;
    for (int c = 0; c < 40 * BIT && !got; c++) begin
      @(negedge clk);
      if (tvalid) got = 1'b1;
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (sb_q.size() == 0) begin
      check({tag, "_unexpected"}, {22'd0, tuser, tdata}, 32'hFFFF_FFFF);
    end else begin
      exp = sb_q.pop_front();
      check(tag, {22'd0, tuser, tdata}, {22'd0, exp});
    end
    @(posedge clk);
    #1;
    tready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   lat;
    rst = 1'b1; uart_rx = 1'b1; tready = 1'b0; err_clr = 1'b0;
    cfg_div = 32'd15; cfg_data_bits = 2'd3; cfg_stop_bits = 1'b0; cfg_parity = 3'd0;
    repeat (4) @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 0);
    check("rst_errs", {err_parity, err_frame, err_overrun}, 0);
    check("rst_level", fifo_level, 0);
    check("rst_busy", rx_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2 * BIT) @(posedge clk);
    #1;

    // 8N1 0xA5 with latency check from the start of the stop bit
    sb_q.push_back({2'b00, 8'hA5});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(8'hA5 >> i);
    uart_rx = 1'b1;
    lat = -1;
    for (int c = 0; c < 3 * BIT && lat < 0; c++) begin
      @(negedge clk);
      if (tvalid) lat = c;
    end
    n_cmp++;
    assert (lat >= BIT / 2 && lat <= BIT / 2 + 5) else begin
      n_err++;
      $error("FAIL t1_latency observed=%0d expected=%0d..%0d", lat, BIT / 2, BIT / 2 + 5);
    end
    check("t1_level", fifo_level, 1);
    repeat (BIT) @(posedge clk);
    #1;
    expect_beat("t1_beat");

    // 7E2 with a wrong parity bit, then clear
    cfg_data_bits = 2'd2; cfg_parity = 3'd1; cfg_stop_bits = 1'b1;
    send_char(8'h35, 7, int'(!xor_bits(8'h35, 7)), 2, 1'b1, 1'b1, 2'b01);
    expect_beat("t2_beat");
    check("t2_err_parity", err_parity, 1);
    check("t2_err_frame", err_frame, 0);
    pulse_clr();
    check("t2_err_clr", err_parity, 0);

    // correct odd parity on 8 bits, correct mark parity on 5 bits
    cfg_data_bits = 2'd3; cfg_parity = 3'd2; cfg_stop_bits = 1'b0;
    send_char(8'hC3, 8, int'(~xor_bits(8'hC3, 8)), 1, 1'b1, 1'b1, 2'b00);
    expect_beat("t2_odd_beat");
    cfg_data_bits = 2'd0; cfg_parity = 3'd3;
    send_char(8'hF5, 5, 1, 1, 1'b1, 1'b1, 2'b00);
    expect_beat("t2_mark_beat");
    check("t2_no_parity_err", err_parity, 0);

    // framing error followed by a long break
    cfg_data_bits = 2'd3; cfg_parity = 3'd0; cfg_stop_bits = 1'b0;
    send_char(8'h3C, 8, -1, 1, 1'b0, 1'b1, 2'b10);
    repeat (40 * BIT) @(posedge clk);
    #1;
    check("t3_one_char", fifo_level, 1);
    check("t3_busy_low_line", rx_busy, 1);
    expect_beat("t3_beat");
    check("t3_err_frame", err_frame, 1);
    uart_rx = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #1;
    check("t3_level_after", fifo_level, 0);
    check("t3_idle_after", rx_busy, 0);

    // overrun: 17 chars into a 16-deep FIFO
    pulse_clr();
    check("t4_frame_cleared", err_frame, 0);
    tready = 1'b0;
    for (int i = 0; i < 17; i++)
      send_char(8'h40 + 8'(i), 8, -1, 1, 1'b1, (i < 16), 2'b00);
    check("t4_level_full", fifo_level, 16);
    check("t4_overrun", err_overrun, 1);
    for (int i = 0; i < 16; i++) expect_beat($sformatf("t4_drain%0d", i));
    check("t4_level_empty", fifo_level, 0);
    pulse_clr();
    check("t4_overrun_clr", err_overrun, 0);

    // 3-clock glitch must not produce a char
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 2 * BIT; c++) begin
      @(negedge clk);
      seen |= rx_busy;
    end
    check("t5_saw_start", seen, 1);
    check("t5_busy_back", rx_busy, 0);
    check("t5_no_char", fifo_level, 0);

    // reset in the middle of a second char with one char queued
    send_char(8'h11, 8, -1, 1, 1'b1, 1'b0, 2'b00);
    check("t6_queued", fifo_level, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("t6_busy_mid", rx_busy, 1);
    rst = 1'b1;
    #1;
    check("t6_tvalid", tvalid, 0);
    check("t6_level", fifo_level, 0);
    check("t6_busy", rx_busy, 0);
    @(posedge clk); #1;
    uart_rx = 1'b1;
    rst = 1'b0;
    repeat (2 * BIT) @(posedge clk);
    #1;
    send_char(8'h5A, 8, -1, 1, 1'b1, 1'b1, 2'b00);
    expect_beat("t6_beat");
    check("end_queue_empty", sb_q.size(), 0);
    check("end_level", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
